// File: rtl/tw_sched.sv
// tw_sched -- twiddle-multiplier scheduler for a 16-point frame.
//
// On START the block walks sample indices 0..15. Each sample takes two
// enabled cycles: the real part (ED=1) and then the imaginary part (ED=0).
// For each sample it selects a twiddle coefficient from
// e = ADDR[3:2]*ADDR[1:0]. After sample 15 it waits LAT enabled cycles
// (FLUSH) for the multiplier pipeline to drain.
// RDY marks the multiplier result of sample 0. DONE marks the result of
// sample 15.
//
// Parameters
//   LAT    enabled cycles from an ED pulse to the registered multiplier output
// Ports
//   CLK    clock, rising edge
//   RST    asynchronous reset, active low
//   EI     clock enable; nothing changes on edges with EI=0
//   START  frame-start request (sampled with EI=1)
//   ED     data strobe, high on the real-part cycle of each sample
//   MPYJ   multiply result by -j
//   NEG    downstream negate
//   SEL    coefficient select: 00 bypass, 01 0.7071, 10 W^1, 11 W^3
//   ADDR   current sample index
//   BUSY   frame in progress (start through DONE)
//   RDY    pulse: multiplier output of sample 0 is valid
//   DONE   pulse: multiplier output of sample 15 is valid
//   OVR    pulse: START seen while BUSY
//
// Build option
//   TWSCHED_RESTART_EN  when defined, START during RUN restarts the frame
//                       and cancels its pending DONE. Otherwise START
//                       during RUN is ignored, apart from the OVR pulse.
module tw_sched #(
    parameter int LAT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EI,
    input  logic       START,
    output logic       ED,
    output logic       MPYJ,
    output logic       NEG,
    output logic [1:0] SEL,
    output logic [3:0] ADDR,
    output logic       BUSY,
    output logic       RDY,
    output logic       DONE,
    output logic       OVR
);

`ifdef TWSCHED_RESTART_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    // Counters must hold up to LAT+1.
    localparam int CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state;
    logic          phase;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] rdy_cnt;   // countdown to the RDY pulse
    logic [CW-1:0] done_cnt;  // countdown to the DONE pulse
    logic          restart;

    // {SEL, MPYJ, NEG} for the sample at index a.
    function automatic logic [3:0] coef(input logic [3:0] a);
        logic [3:0] e;
        e = {2'b00, a[3:2]} * {2'b00, a[1:0]};
        case (e)
            4'd1:    coef = 4'b1000;
            4'd2:    coef = 4'b0100;
            4'd3:    coef = 4'b1100;
            4'd4:    coef = 4'b0010;
            4'd6:    coef = 4'b0110;
            4'd9:    coef = 4'b1001;
            default: coef = 4'b0000;
        endcase
    endfunction

    // A new frame may begin from IDLE or FLUSH. In FLUSH the old frame's
    // DONE countdown keeps running. From RUN a new frame begins only in
    // restart builds.
    assign restart = START && (state == IDLE || state == FLUSH ||
                               (state == RUN && RESTART_EN));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            phase    <= 1'b0;
            ADDR     <= 4'd0;
            fcnt     <= '0;
            rdy_cnt  <= '0;
            done_cnt <= '0;
            ED       <= 1'b0;
            MPYJ     <= 1'b0;
            NEG      <= 1'b0;
            SEL      <= 2'b00;
            BUSY     <= 1'b0;
            RDY      <= 1'b0;
            DONE     <= 1'b0;
            OVR      <= 1'b0;
        end else if (EI) begin
            OVR  <= START && (state != IDLE);
            RDY  <= (rdy_cnt == CW'(1));
            DONE <= (done_cnt == CW'(1));
            if (rdy_cnt != '0)  rdy_cnt  <= rdy_cnt - CW'(1);
            if (done_cnt != '0) done_cnt <= done_cnt - CW'(1);

            if (restart) begin
                state              <= RUN;
                BUSY               <= 1'b1;
                phase              <= 1'b0;
                ADDR               <= 4'd0;
                ED                 <= 1'b1;
                {SEL, MPYJ, NEG}   <= coef(4'd0);
                fcnt               <= '0;
                rdy_cnt            <= CW'(LAT);
                // Restart from RUN abandons the current frame's DONE.
                if (state == RUN) done_cnt <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (!phase) begin
                            phase <= 1'b1;
                            ED    <= 1'b0;
                        end else begin
                            phase <= 1'b0;
                            if (ADDR == 4'd15) begin
                                state            <= FLUSH;
                                ADDR             <= 4'd0;
                                {SEL, MPYJ, NEG} <= 4'b0000;
                            end else begin
                                ADDR             <= ADDR + 4'd1;
                                ED               <= 1'b1;
                                {SEL, MPYJ, NEG} <= coef(ADDR + 4'd1);
                                // Entering the ED of sample 15. DONE comes
                                // LAT+1 enabled cycles later.
                                if (ADDR == 4'd14) done_cnt <= CW'(LAT + 1);
                            end
                        end
                    end
                    FLUSH: begin
                        if (fcnt == CW'(LAT - 1)) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            fcnt <= fcnt + CW'(1);
                        end
                    end
                    default: ;  // IDLE: outputs already zero
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tw_sched.sv
// Scoreboard bench for tw_sched. Each START pushes the expected ED/ADDR/
// coefficient events and the RDY, DONE and OVR pulse times, counted in
// enabled cycles. The monitor pops each entry when its cycle comes up.
module tb_tw_sched;
    localparam int LAT = 4;

    logic       CLK = 1'b0;
    logic       RST, EI, START;
    logic       ED, MPYJ, NEG, BUSY, RDY, DONE, OVR;
    logic [1:0] SEL;
    logic [3:0] ADDR;
    logic [12:0] outs;

    int   total = 0;
    int   bad = 0;
    int   ecyc = 0;
    logic last_ei = 1'b0;
    logic tog = 1'b0;
    int   busy_end = -1;
    int   run_end = -1;
    logic [12:0] prev_o = '0;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [3:0] cf;
    } ed_t;

    ed_t edq[$];
    int  rdyq[$];
    int  doneq[$];
    int  ovrq[$];

    always #5 CLK = ~CLK;

    tw_sched #(.LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .EI(EI), .START(START),
        .ED(ED), .MPYJ(MPYJ), .NEG(NEG), .SEL(SEL), .ADDR(ADDR),
        .BUSY(BUSY), .RDY(RDY), .DONE(DONE), .OVR(OVR)
    );

    assign outs = {ED, MPYJ, NEG, SEL, ADDR, BUSY, RDY, DONE, OVR};

    always @(posedge CLK) begin
        last_ei <= EI;
        if (EI) ecyc <= ecyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (ecyc=%0d)", tag, got, exp, ecyc);
        end
    endtask

    function automatic logic [3:0] exp_cf(input int a);
        int e;
        e = (a / 4) * (a % 4);
        case (e)
            1:       return 4'b1000;
            2:       return 4'b0100;
            3:       return 4'b1100;
            4:       return 4'b0010;
            6:       return 4'b0110;
            9:       return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic push_frame(input int b);
        ed_t e;
        for (int i = 0; i < 16; i++) begin
            e.cyc  = b + 2 * i;
            e.addr = 4'(i);
            e.cf   = exp_cf(i);
            edq.push_back(e);
        end
        rdyq.push_back(b + LAT);
        doneq.push_back(b + 31 + LAT);
        run_end  = b + 31;
        busy_end = b + 31 + LAT;
    endtask

    // b = enabled cycle in which the new frame's first ED shows.
    task automatic on_start(input int b);
        bit busy, in_run;
        busy   = (b - 1) <= busy_end;
        in_run = (b - 1) <= run_end;
        if (busy) ovrq.push_back(b);
        if (!busy || !in_run) begin
            push_frame(b);
        end else begin
`ifdef TWSCHED_RESTART_EN
            while (edq.size() > 0 && edq[edq.size()-1].cyc >= b) void'(edq.pop_back());
            while (rdyq.size() > 0 && rdyq[rdyq.size()-1] >= b) void'(rdyq.pop_back());
            while (doneq.size() > 0 && doneq[doneq.size()-1] >= b) void'(doneq.pop_back());
            push_frame(b);
`endif
        end
    endtask

    // Drive inputs for the next edge, then wait until just after the
    // following negedge.
    task automatic step(input logic st);
        if (st) begin
            EI    = 1'b1;
            START = 1'b1;
            on_start(ecyc + 1);
        end else begin
            START = 1'b0;
            EI    = tog ? ~EI : 1'b1;
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic launch(output int b);
        b = ecyc + 1;
        step(1'b1);
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (ecyc < target && n < 400) begin
            step(1'b0);
            n++;
        end
        if (ecyc < target) chk("timeout", 32'(ecyc), 32'(target));
    endtask

    // Monitor: runs once per enabled edge. It also checks that edges
    // with EI=0 leave every output untouched.
    always @(negedge CLK) begin
        ed_t e;
        if (RST === 1'b1) begin
            if (last_ei) begin
                if (edq.size() > 0 && edq[0].cyc == ecyc) begin
                    e = edq.pop_front();
                    chk("ed", ED, 1);
                    chk("addr", ADDR, e.addr);
                    chk("coef", {SEL, MPYJ, NEG}, e.cf);
                end else begin
                    chk("ed_x", ED, 0);
                end
                if (rdyq.size() > 0 && rdyq[0] == ecyc) begin
                    void'(rdyq.pop_front());
                    chk("rdy", RDY, 1);
                end else chk("rdy_x", RDY, 0);
                if (doneq.size() > 0 && doneq[0] == ecyc) begin
                    void'(doneq.pop_front());
                    chk("done", DONE, 1);
                end else chk("done_x", DONE, 0);
                if (ovrq.size() > 0 && ovrq[0] == ecyc) begin
                    void'(ovrq.pop_front());
                    chk("ovr", OVR, 1);
                end else chk("ovr_x", OVR, 0);
                chk("busy", BUSY, 32'(ecyc <= busy_end));
                if (ecyc > busy_end) chk("idle", {ED, MPYJ, NEG, SEL, ADDR}, 0);
            end else begin
                chk("freeze", outs, prev_o);
            end
        end
        prev_o = outs;
    end

    initial begin
        int b, b2;
        RST = 1'b0; EI = 1'b0; START = 1'b0;
        repeat (3) @(negedge CLK);
        #1 chk("rst_out", outs, 0);
        RST = 1'b1;
        @(negedge CLK);
        #1;

        // Basic frame with EI held high.
        launch(b);
        run_until(b + 40);

        // EI toggling: same schedule in enabled cycles.
        tog = 1'b1;
        launch(b);
        run_until(b + 40);
        tog = 1'b0;

        // START while ADDR=8 is shown.
        launch(b);
        run_until(b + 16);
        launch(b2);
        run_until(b + 80);

        // START during FLUSH: the old DONE must still fire.
        launch(b);
        run_until(b + 32);
        launch(b2);
        run_until(b2 + 40);

        // Asynchronous reset at ADDR=9, then a clean frame.
        launch(b);
        run_until(b + 18);
        #2 RST = 1'b0;
        #1 chk("rst_async", outs, 0);
        edq.delete(); rdyq.delete(); doneq.delete(); ovrq.delete();
        busy_end = -1;
        run_end  = -1;
        @(negedge CLK);
        #1 RST = 1'b1;
        run_until(ecyc + 5);
        launch(b);
        run_until(b + 40);

        chk("edq_left", edq.size(), 0);
        chk("rdyq_left", rdyq.size(), 0);
        chk("doneq_left", doneq.size(), 0);
        chk("ovrq_left", ovrq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tw_sched.md
TW_SCHED -- requirements
Module: tw_sched

Interface
REQ-001 Parameter LAT, default 4: EI-qualified cycles from an ED pulse to the multiplier's registered output for that sample.
REQ-002 CLK  input  1  system clock, rising edge.
REQ-003 RST  input  1  asynchronous reset, active-low.
REQ-004 EI  input  1  clock enable; state advances only on edges with EI=1.
REQ-005 START  input  1  frame-start request, sampled when EI=1.
REQ-006 ED  output  1  multiplier data strobe, high on the real-part cycle of each sample.
REQ-007 MPYJ  output  1  multiplier "result times -j" control.
REQ-008 NEG  output  1  downstream negate control, aligned with ED.
REQ-009 SEL  output  2  coefficient select: 00 bypass, 01 0.7071, 10 W^1, 11 W^3.
REQ-010 ADDR  output  4  sample index i of the current sample.
REQ-011 BUSY  output  1  high from frame start until DONE.
REQ-012 RDY  output  1  one-cycle pulse when the multiplier output of sample 0 is valid.
REQ-013 DONE  output  1  one-cycle pulse when the multiplier output of sample 15 is valid.
REQ-014 OVR  output  1  one-cycle pulse when START arrives while BUSY.

Function
REQ-015 The FSM states are IDLE, RUN and FLUSH; the FSM shall be in IDLE after reset.
REQ-016 IDLE->RUN on EI & START; ADDR=0 and phase=0 in that cycle.
REQ-017 In RUN, each sample shall occupy two EI cycles: phase 0 (ED=1, real part) and phase 1 (ED=0, imaginary part).
REQ-018 After phase 1, ADDR shall increment modulo 16; RUN->FLUSH after phase 1 of ADDR=15.
REQ-019 FLUSH shall count LAT EI cycles, then pulse DONE and return to IDLE.
REQ-020 FLUSH & START shall go directly to RUN with ADDR=0; DONE for the old frame shall still pulse on schedule.
REQ-021 Coefficient exponent: e = ADDR[3:2]*ADDR[1:0] (4-bit product).
REQ-022 (SEL,MPYJ,NEG) per e: 0->(00,0,0); 1->(10,0,0); 2->(01,0,0); 3->(11,0,0); 4->(00,1,0); 6->(01,1,0); 9->(10,0,1); any other e->(00,0,0).
REQ-023 SEL, MPYJ and NEG shall be registered and held constant across both phases of a sample.
REQ-024 RDY shall be a pulse exactly LAT EI cycles after the ED of sample 0.
REQ-025 DONE shall be a pulse exactly LAT+1 EI cycles after the ED of sample 15.
REQ-026 With EI=0, all state and outputs shall freeze; pulses shall not repeat and shall not be lost.
REQ-027 In IDLE, ED, MPYJ, NEG and SEL shall be 0, and ADDR shall hold 0.

Reset
REQ-028 While RST=0 (asynchronous), the FSM shall be IDLE, phase and ADDR 0, the latency counter 0, and all outputs 0.
REQ-029 A reset mid-frame shall abort the frame, with no RDY or DONE for the aborted frame.

Configuration
REQ-030 Macro TWSCHED_RESTART_EN defined: START in RUN shall restart at ADDR=0, phase 0, cancel the pending DONE and pulse OVR.
REQ-031 Macro TWSCHED_RESTART_EN undefined: START in RUN shall be ignored and OVR shall pulse; the frame completes normally.

Verification
REQ-032 Reset, EI=1, START pulse at cycle 0 -> ED high at cycles 0,2,...,30; ADDR 0..15; RDY at cycle 4; DONE at cycle 35; BUSY cycles 0..35.
REQ-033 Coefficient sweep: ADDR=5 -> SEL=10,MPYJ=0,NEG=0; ADDR=6 -> 01,0,0; ADDR=10 -> 00,1,0; ADDR=11 -> 01,1,0; ADDR=15 -> 10,0,1; ADDR=7 -> 11,0,0.
REQ-034 EI toggling 1,0,1,0 through a frame -> same sequence as REQ-032 with cycle counts doubled; no lost or duplicated pulses.
REQ-035 START at ADDR=8 -> with macro: OVR pulse, ADDR=0 next, no DONE from first frame; without macro: OVR pulse, DONE at cycle 35.
REQ-036 RST low at ADDR=9 -> all outputs 0 immediately, no RDY/DONE; a new START frame behaves as REQ-032.
REQ-037 START during FLUSH -> new frame ADDR=0 immediately; old DONE still pulses on schedule.
